system_memory_v3: RTL and testbench
===================================

# system_memory_v3

Parametrised grid-state memory for the Conway engine, holding a full WIDTH×HEIGHT board in one flattened register. It extends the previous single-row memory with three additions: a serial unload (dump) path for readback, a load-progress counter with a completion flag, and a generation counter with a still-life (stable) detector. It sits between the serial host loader, the next-state logic (GRID_IN), and the display/readback path (DATA_OUT, SERIAL_OUT).

## Interface
- WIDTH, default 8: columns per row.
- HEIGHT, default 8: rows.
- GEN_BITS, default 16: width of the generation counter.
- N (local) = WIDTH*HEIGHT; CW (local) = $clog2(N+1).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-low reset.
- GRID_IN  in  N  next-generation board from the cell logic.
- SERIAL_IN  in  1  serial load data.
- LOAD_MODE  in  1  serial load enable.
- RUN_MODE  in  1  parallel load (advance generation) enable.
- DUMP_MODE  in  1  serial unload enable.
- DATA_OUT  out  N  current board.
- SERIAL_OUT  out  1  equals DATA_OUT[N-1] (combinational from the register).
- LOAD_COUNT  out  CW  bits shifted in during the current load session, saturating at N.
- LOAD_DONE  out  1  high when LOAD_COUNT == N.
- GENERATION  out  GEN_BITS  number of RUN loads since the last reset or load session; wraps.
- STABLE  out  1  the last RUN load wrote a value identical to the previous contents.

## Operation
- Mode priority per cycle: RUN_MODE > LOAD_MODE > DUMP_MODE > hold.
- RESET low at an edge: DATA_OUT, LOAD_COUNT, GENERATION, STABLE and the internal previous-load flag all go to 0. Reset overrides every mode.
- Hold (no mode asserted): all state is retained. GRID_IN and SERIAL_IN are ignored.
- RUN:
  - DATA_OUT <= GRID_IN.
  - GENERATION <= GENERATION+1, modulo 2^GEN_BITS.
  - STABLE <= (GRID_IN == DATA_OUT), compared against the pre-edge contents.
  - LOAD_COUNT <= 0 and the previous-load flag is cleared.
- LOAD:
  - DATA_OUT <= {DATA_OUT[N-2:0], SERIAL_IN}. The first bit shifted in ends up at the MSB after N shifts.
  - First LOAD cycle after any non-LOAD cycle (session start): LOAD_COUNT <= 1, GENERATION <= 0, STABLE <= 0.
  - Later cycles in the same session: LOAD_COUNT <= min(LOAD_COUNT+1, N).
  - Shifting continues past N; the oldest bits fall off the MSB.
- DUMP:
  - DATA_OUT <= {DATA_OUT[N-2:0], DATA_OUT[N-1]} (rotate left).
  - SERIAL_OUT presents bits MSB-first, in the same order they were loaded.
  - After exactly N dump cycles DATA_OUT equals its pre-dump value.
  - Counters and STABLE are unchanged.
- LOAD_DONE = (LOAD_COUNT == N). It stays high through hold and dump, and clears on a RUN load, a new load session, or reset.
- Mode changes between cycles need no idle gap. A session restart is detected from the registered previous-cycle LOAD-won flag.

## Timing
- All outputs are registered with 1-cycle latency from the qualifying edge. SERIAL_OUT and LOAD_DONE are pure decodes of registers.
- Boundary conditions:
  - Reset mid-load: the session is abandoned; the next LOAD cycle starts a new session at LOAD_COUNT = 1.
  - Reset mid-dump: the board is cleared, with no restore.
  - RUN and LOAD high together: RUN wins, and LOAD_COUNT goes to 0. If LOAD stays high the next cycle, that cycle starts a new session.
  - GENERATION at 2^GEN_BITS-1 followed by RUN: it wraps to 0.
- No throughput limit: one shift, rotate or load per cycle.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 (N=8) unless noted.

- Reset, then 20 cycles with no mode set while GRID_IN=8'hFF and SERIAL_IN=1 -> DATA_OUT=0, GENERATION=0, LOAD_COUNT=0, LOAD_DONE=0.
- LOAD with SERIAL_IN = 1,0,1,1,0,0,1,0 -> DATA_OUT=8'b10110010, LOAD_COUNT=8, LOAD_DONE=1. Two more LOAD cycles with SERIAL_IN=1 -> DATA_OUT=8'b11001011, LOAD_COUNT stays 8.
- From 8'b10110010, 8 DUMP cycles -> SERIAL_OUT sequence 1,0,1,1,0,0,1,0, and DATA_OUT=8'b10110010 afterwards.
- RUN and LOAD both high with GRID_IN=8'h3C -> DATA_OUT=8'h3C, GENERATION=1, STABLE=0, LOAD_COUNT=0. A second RUN with the same GRID_IN -> GENERATION=2, STABLE=1. RUN with GRID_IN=8'h3D -> STABLE=0.
- GEN_BITS=2: five RUN cycles -> GENERATION=1 (wrapped). One LOAD cycle -> GENERATION=0, LOAD_COUNT=1.
- LOAD 3 bits, RESET low for 1 cycle, then LOAD 1 bit -> all outputs 0 after reset, then LOAD_COUNT=1 and DATA_OUT=SERIAL_IN.

Source files
------------

// File: rtl/system_memory_v3.sv
// Grid-state memory for the Conway engine: parallel RUN load, serial LOAD shift-in,
// serial DUMP rotate-out, load-progress counter, generation counter and still-life flag.
module system_memory_v3 #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int GEN_BITS = 16,
  localparam int N  = WIDTH * HEIGHT,
  localparam int CW = $clog2(N + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N-1:0]        GRID_IN,
  input  logic                SERIAL_IN,
  input  logic                LOAD_MODE,
  input  logic                RUN_MODE,
  input  logic                DUMP_MODE,
  output logic [N-1:0]        DATA_OUT,
  output logic                SERIAL_OUT,
  output logic [CW-1:0]       LOAD_COUNT,
  output logic                LOAD_DONE,
  output logic [GEN_BITS-1:0] GENERATION,
  output logic                STABLE
);

  localparam logic [CW-1:0]       COUNT_FULL = CW'(N);
  localparam logic [CW-1:0]       COUNT_ONE  = CW'(1);
  localparam logic [GEN_BITS-1:0] GEN_ONE    = GEN_BITS'(1);

  logic [N-1:0]        data_reg, data_next;
  logic [CW-1:0]       load_count_reg, load_count_next;
  logic [GEN_BITS-1:0] gen_reg, gen_next;
  logic                stable_reg, stable_next;
  logic                prev_load_reg, prev_load_next;

  always_comb begin
    data_next       = data_reg;
    load_count_next = load_count_reg;
    gen_next        = gen_reg;
    stable_next     = stable_reg;
    prev_load_next  = 1'b0;

    if (RUN_MODE) begin
      data_next       = GRID_IN;
      gen_next        = gen_reg + GEN_ONE;
      stable_next     = (GRID_IN == data_reg);
      load_count_next = '0;
    end else if (LOAD_MODE) begin
      data_next      = {data_reg[N-2:0], SERIAL_IN};
      prev_load_next = 1'b1;
      // A LOAD cycle not preceded by a winning LOAD cycle opens a fresh session.
      if (!prev_load_reg) begin
        load_count_next = COUNT_ONE;
        gen_next        = '0;
        stable_next     = 1'b0;
      end else if (load_count_reg != COUNT_FULL) begin
        load_count_next = load_count_reg + COUNT_ONE;
      end
    end else if (DUMP_MODE) begin
      data_next = {data_reg[N-2:0], data_reg[N-1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      data_reg       <= '0;
      load_count_reg <= '0;
      gen_reg        <= '0;
      stable_reg     <= 1'b0;
      prev_load_reg  <= 1'b0;
    end else begin
      data_reg       <= data_next;
      load_count_reg <= load_count_next;
      gen_reg        <= gen_next;
      stable_reg     <= stable_next;
      prev_load_reg  <= prev_load_next;
    end
  end

  assign DATA_OUT   = data_reg;
  assign SERIAL_OUT = data_reg[N-1];
  assign LOAD_COUNT = load_count_reg;
  assign LOAD_DONE  = (load_count_reg == COUNT_FULL);
  assign GENERATION = gen_reg;
  assign STABLE     = stable_reg;

endmodule

// File: tb/tb_system_memory_v3.sv
// Directed bench for system_memory_v3 at WIDTH=4, HEIGHT=2; a second instance with
// GEN_BITS=2 shares the stimulus to exercise generation wrap.
module tb_system_memory_v3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] grid_in;
  logic       serial_in, load_mode, run_mode, dump_mode;

  logic [7:0]  data_out, data_out2;
  logic        serial_out, serial_out2;
  logic [3:0]  load_count, load_count2;
  logic        load_done, load_done2;
  logic [15:0] generation;
  logic [1:0]  generation2;
  logic        stable, stable2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  system_memory_v3 #(.WIDTH(4), .HEIGHT(2), .GEN_BITS(16)) dut (
    .CLK(clk), .RESET(reset_n), .GRID_IN(grid_in), .SERIAL_IN(serial_in),
    .LOAD_MODE(load_mode), .RUN_MODE(run_mode), .DUMP_MODE(dump_mode),
    .DATA_OUT(data_out), .SERIAL_OUT(serial_out), .LOAD_COUNT(load_count),
    .LOAD_DONE(load_done), .GENERATION(generation), .STABLE(stable)
  );

  system_memory_v3 #(.WIDTH(4), .HEIGHT(2), .GEN_BITS(2)) dut_g2 (
    .CLK(clk), .RESET(reset_n), .GRID_IN(grid_in), .SERIAL_IN(serial_in),
    .LOAD_MODE(load_mode), .RUN_MODE(run_mode), .DUMP_MODE(dump_mode),
    .DATA_OUT(data_out2), .SERIAL_OUT(serial_out2), .LOAD_COUNT(load_count2),
    .LOAD_DONE(load_done2), .GENERATION(generation2), .STABLE(stable2)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_modes(input logic run, input logic load, input logic dump);
    run_mode  = run;
    load_mode = load;
    dump_mode = dump;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; set_modes(0, 0, 0); grid_in = 8'hFF; serial_in = 1'b1;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h want 00", data_out); else passed++;
    total++; if (generation !== 16'd0) $display("FAIL reset_gen: got %0d want 0", generation); else passed++;
    total++; if (load_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", load_count); else passed++;
    total++; if (load_done !== 1'b0) $display("FAIL reset_done: got %b want 0", load_done); else passed++;
    total++; if (stable !== 1'b0) $display("FAIL reset_stable: got %b want 0", stable); else passed++;
    $display("reset+20 idle: data=%h gen=%0d count=%0d done=%b", data_out, generation, load_count, load_done);
  endtask

  task automatic test_load();
    logic [7:0] bits;
    bits = 8'b10110010;
    set_modes(0, 1, 0);
    for (int i = 7; i >= 0; i--) begin
      serial_in = bits[i];
      step();
      total++;
      if (load_count !== 4'(8 - i))
        $display("FAIL load_count_step: got %0d want %0d", load_count, 8 - i);
      else passed++;
    end
    total++; if (data_out !== 8'b10110010) $display("FAIL load_data: got %b want 10110010", data_out); else passed++;
    total++; if (load_done !== 1'b1) $display("FAIL load_done: got %b want 1", load_done); else passed++;
    serial_in = 1'b1;
    step(); step();
    total++; if (data_out !== 8'b11001011) $display("FAIL load_overrun_data: got %b want 11001011", data_out); else passed++;
    total++; if (load_count !== 4'd8) $display("FAIL load_saturate: got %0d want 8", load_count); else passed++;
    $display("load 10110010 +2: data=%b count=%0d done=%b", data_out, load_count, load_done);

    // Hold cycle ends the session; reload starts again from count 1.
    set_modes(0, 0, 0); step();
    total++; if (load_done !== 1'b1) $display("FAIL hold_done: got %b want 1", load_done); else passed++;
    set_modes(0, 1, 0);
    for (int i = 7; i >= 0; i--) begin
      serial_in = bits[i];
      step();
      if (i == 7) begin
        total++; if (load_count !== 4'd1) $display("FAIL reload_start: got %0d want 1", load_count); else passed++;
      end
    end
    set_modes(0, 0, 0);
    total++; if (data_out !== 8'b10110010) $display("FAIL reload_data: got %b want 10110010", data_out); else passed++;
    $display("reload: data=%b count=%0d", data_out, load_count);
  endtask

  task automatic test_dump();
    logic [7:0] exp_seq;
    exp_seq = 8'b10110010;
    set_modes(0, 0, 1);
    for (int i = 7; i >= 0; i--) begin
      total++;
      if (serial_out !== exp_seq[i])
        $display("FAIL dump_serial: bit %0d got %b want %b", 7 - i, serial_out, exp_seq[i]);
      else passed++;
      step();
    end
    set_modes(0, 0, 0);
    total++; if (data_out !== 8'b10110010) $display("FAIL dump_restore: got %b want 10110010", data_out); else passed++;
    total++; if (load_count !== 4'd8) $display("FAIL dump_count: got %0d want 8", load_count); else passed++;
    $display("dump x8: data=%b count=%0d", data_out, load_count);
  endtask

  task automatic test_run_load();
    set_modes(1, 1, 0); grid_in = 8'h3C; serial_in = 1'b1;
    step();
    total++; if (data_out !== 8'h3C) $display("FAIL run_data: got %h want 3c", data_out); else passed++;
    total++; if (generation !== 16'd1) $display("FAIL run_gen1: got %0d want 1", generation); else passed++;
    total++; if (stable !== 1'b0) $display("FAIL run_stable0: got %b want 0", stable); else passed++;
    total++; if (load_count !== 4'd0) $display("FAIL run_count: got %0d want 0", load_count); else passed++;
    total++; if (load_done !== 1'b0) $display("FAIL run_done: got %b want 0", load_done); else passed++;
    set_modes(1, 0, 0);
    step();
    total++; if (generation !== 16'd2) $display("FAIL run_gen2: got %0d want 2", generation); else passed++;
    total++; if (stable !== 1'b1) $display("FAIL run_stable1: got %b want 1", stable); else passed++;
    grid_in = 8'h3D;
    step();
    total++; if (stable !== 1'b0) $display("FAIL run_unstable: got %b want 0", stable); else passed++;
    total++; if (generation !== 16'd3) $display("FAIL run_gen3: got %0d want 3", generation); else passed++;
    // RUN+LOAD then LOAD alone: the LOAD-only cycle opens a new session.
    set_modes(1, 1, 0);
    step();
    set_modes(0, 1, 0); serial_in = 1'b1;
    step();
    set_modes(0, 0, 0);
    total++; if (load_count !== 4'd1) $display("FAIL run_then_load_count: got %0d want 1", load_count); else passed++;
    total++; if (data_out !== 8'h7B) $display("FAIL run_then_load_data: got %h want 7b", data_out); else passed++;
    total++; if (generation !== 16'd0) $display("FAIL run_then_load_gen: got %0d want 0", generation); else passed++;
    $display("run/load: data=%h gen=%0d stable=%b count=%0d", data_out, generation, stable, load_count);
  endtask

  task automatic test_gen_wrap();
    reset_n = 1'b0; set_modes(0, 0, 0); step();
    reset_n = 1'b1;
    set_modes(1, 0, 0); grid_in = 8'h00;
    for (int i = 0; i < 5; i++) step();
    total++; if (generation2 !== 2'd1) $display("FAIL gen_wrap: got %0d want 1", generation2); else passed++;
    total++; if (generation !== 16'd5) $display("FAIL gen_nowrap: got %0d want 5", generation); else passed++;
    set_modes(0, 1, 0); serial_in = 1'b1;
    step();
    set_modes(0, 0, 0);
    total++; if (generation2 !== 2'd0) $display("FAIL gen_load_clear: got %0d want 0", generation2); else passed++;
    total++; if (load_count2 !== 4'd1) $display("FAIL gen_load_count: got %0d want 1", load_count2); else passed++;
    $display("gen wrap: gen2=%0d gen16=%0d count=%0d", generation2, generation, load_count2);
  endtask

  task automatic test_reset_midload();
    set_modes(0, 1, 0); serial_in = 1'b1;
    step(); step(); step();
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    total++; if (data_out !== 8'h00) $display("FAIL midload_reset_data: got %h want 00", data_out); else passed++;
    total++; if (load_count !== 4'd0) $display("FAIL midload_reset_count: got %0d want 0", load_count); else passed++;
    serial_in = 1'b1;
    step();
    set_modes(0, 0, 0);
    total++; if (load_count !== 4'd1) $display("FAIL midload_restart_count: got %0d want 1", load_count); else passed++;
    total++; if (data_out !== 8'h01) $display("FAIL midload_restart_data: got %h want 01", data_out); else passed++;
    $display("reset mid-load: data=%h count=%0d", data_out, load_count);
  endtask

  task automatic test_reset_middump();
    set_modes(0, 0, 1);
    step(); step();
    reset_n = 1'b0; step();
    reset_n = 1'b1; set_modes(0, 0, 0);
    step();
    total++; if (data_out !== 8'h00) $display("FAIL middump_reset: got %h want 00", data_out); else passed++;
    $display("reset mid-dump: data=%h", data_out);
  endtask

  initial begin
    reset_n = 1'b0; grid_in = '0; serial_in = 1'b0;
    set_modes(0, 0, 0);
    #2;
    test_reset();
    test_load();
    test_dump();
    test_run_load();
    test_gen_wrap();
    test_reset_midload();
    test_reset_middump();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
